bit_eight_divider: RTL

Sequential 16-by-8 unsigned restoring divider: the inverse companion of the 8-bit shift-add multiplier. It yields an 8-bit quotient and 8-bit remainder, so a multiplier product can be divided back down by one of its factors. It uses the same St/Done handshake as the multiplier and slots beside it in the arithmetic datapath. An optional input/output register stage matches the multiplier's pipelined wrapper.

---
 rtl/bit_eight_divider.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bit_eight_divider.sv
// Sequential 16/8 unsigned restoring divider with St/Done handshake.
// Define DIV_PIPE_REG_EN to add one input and one output register stage.
module bit_eight_divider (
   input  logic        Clk,
   input  logic        rst,
   input  logic        St,
   input  logic [15:0] Dividend,
   input  logic [7:0]  Divisor,
   output logic        Busy,
   output logic        Done,
   output logic        Ovf,
   output logic [7:0]  Quotient,
   output logic [7:0]  Remainder
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  cnt;
   logic [15:0] acc;
   logic [7:0]  dvs;

   logic        st_c;
   logic [15:0] dvd_c;
   logic [7:0]  dvs_c;

   logic        done_c;
   logic        ovf_c;
   logic [7:0]  quo_c;
   logic [7:0]  rem_c;

   logic [8:0]  upper;
   logic        q_bit;
   logic [7:0]  rem8;
   logic [15:0] acc_nx;
   logic        ovf_test;

   // upper holds the shifted partial remainder including the carried-out MSB
   always_comb begin
      upper    = acc[15:7];
      q_bit    = (upper >= {1'b0, dvs});
      rem8     = q_bit ? (upper[7:0] - dvs) : upper[7:0];
      acc_nx   = {rem8, acc[6:0], q_bit};
      ovf_test = (dvd_c[15:8] >= dvs_c);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (st_c)
               state_nx = ovf_test ? S_DONE : S_DIV;
         end
         S_DIV: begin
            if (cnt == 3'd7)
               state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         dvs    <= '0;
         done_c <= 1'b0;
         ovf_c  <= 1'b0;
         quo_c  <= '0;
         rem_c  <= '0;
      end else begin
         done_c <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (st_c) begin
                  if (ovf_test) begin
                     ovf_c  <= 1'b1;
                     quo_c  <= '0;
                     rem_c  <= '0;
                     done_c <= 1'b1;
                  end else begin
                     acc <= dvd_c;
                     dvs <= dvs_c;
                     cnt <= '0;
                  end
               end
            end
            S_DIV: begin
               acc <= acc_nx;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  quo_c  <= acc_nx[7:0];
                  rem_c  <= acc_nx[15:8];
                  ovf_c  <= 1'b0;
                  done_c <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign Busy = (state != S_IDLE);

`ifdef DIV_PIPE_REG_EN
   always_ff @(posedge Clk) begin
      if (rst) begin
         st_c  <= 1'b0;
         dvd_c <= '0;
         dvs_c <= '0;
      end else begin
         st_c  <= St;
         dvd_c <= Dividend;
         dvs_c <= Divisor;
      end
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         Done      <= 1'b0;
         Ovf       <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
      end else begin
         Done      <= done_c;
         Ovf       <= ovf_c;
         Quotient  <= quo_c;
         Remainder <= rem_c;
      end
   end
`else
   assign st_c      = St;
   assign dvd_c     = Dividend;
   assign dvs_c     = Divisor;
   assign Done      = done_c;
   assign Ovf       = ovf_c;
   assign Quotient  = quo_c;
   assign Remainder = rem_c;
`endif

endmodule
